// File: rtl/pong_game_ctrl.sv
// Per-frame Pong sequencer: on each VSYNC rising edge moves paddles and ball, resolves collisions, keeps score.
// Optional macro PONG_AI_EN: the right paddle tracks the ball instead of following up_r/dn_r.
module pong_game_ctrl #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BALL_SIZE  = 8,
    parameter int PAD_W      = 8,
    parameter int PAD_H      = 64,
    parameter int PAD_X_L    = 16,
    parameter int PAD_X_R    = 616,
    parameter int BALL_SPEED = 2,
    parameter int PAD_SPEED  = 4,
    parameter int WIN_SCORE  = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       serve,
    input  logic       up_l,
    input  logic       dn_l,
    input  logic       up_r,
    input  logic       dn_r,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] pad_l_y,
    output logic [9:0] pad_r_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       playing,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_SERVE, S_WAIT_TICK, S_MOVE_PAD, S_MOVE_BALL, S_CHECK, S_POINT, S_GAME_OVER
    } state_t;

    localparam logic [9:0]        C_BALL_X0   = 10'(H_RES / 2 - BALL_SIZE / 2);
    localparam logic [9:0]        C_BALL_Y0   = 10'(V_RES / 2 - BALL_SIZE / 2);
    localparam logic [9:0]        C_PAD_Y0    = 10'((V_RES - PAD_H) / 2);
    localparam logic [9:0]        C_PAD_MAX   = 10'(V_RES - PAD_H);
    localparam logic [9:0]        C_PAD_SPD   = 10'(PAD_SPEED);
    localparam logic signed [10:0] C_BSPD     = 11'(BALL_SPEED);
    localparam logic signed [10:0] C_BX_MAX   = 11'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] C_BY_MAX   = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0]       C_BSZ       = 11'(BALL_SIZE);
    localparam logic [10:0]       C_PADH      = 11'(PAD_H);
    localparam logic [10:0]       C_HALF_PADH = 11'(PAD_H / 2);
    localparam logic [10:0]       C_HALF_BSZ  = 11'(BALL_SIZE / 2);
    localparam logic [10:0]       C_PSPD11    = 11'(PAD_SPEED);
    localparam logic [10:0]       C_XL_EDGE   = 11'(PAD_X_L + PAD_W);
    localparam logic [10:0]       C_XL        = 11'(PAD_X_L);
    localparam logic [10:0]       C_XR        = 11'(PAD_X_R);
    localparam logic [10:0]       C_XR_EDGE   = 11'(PAD_X_R + PAD_W);
    localparam logic [9:0]        C_BX_HIT_L  = 10'(PAD_X_L + PAD_W);
    localparam logic [9:0]        C_BX_HIT_R  = 10'(PAD_X_R - BALL_SIZE);
    localparam logic [9:0]        C_BX_GOAL_R = 10'(H_RES - BALL_SIZE);
    localparam logic [3:0]        C_WIN       = 4'(WIN_SCORE);

    state_t            r_state, w_state;
    logic              r_vsync_d;
    logic [9:0]        r_ball_x, r_ball_y, r_pad_l, r_pad_r;
    logic [9:0]        w_ball_x, w_ball_y, w_pad_l, w_pad_r;
    logic [3:0]        r_score_l, r_score_r, w_score_l, w_score_r;
    logic              r_dir_x, r_dir_y, r_loser_l, r_playing, r_game_over;
    logic              w_dir_x, w_dir_y, w_loser_l, w_playing, w_game_over;
    logic              w_tick, w_ov_l, w_ov_r, w_ai_up, w_ai_dn;
    logic signed [10:0] w_bx_mv, w_by_mv;
    logic [9:0]        w_pad_l_step, w_pad_r_step;

    function automatic logic [9:0] pad_step(input logic [9:0] pad, input logic up, input logic dn);
        logic [9:0] res;
        if (up && !dn) begin
            res = (pad < C_PAD_SPD) ? 10'd0 : pad - C_PAD_SPD;
        end else if (dn && !up) begin
            res = (pad > C_PAD_MAX - C_PAD_SPD) ? C_PAD_MAX : pad + C_PAD_SPD;
        end else begin
            res = pad;
        end
        return res;
    endfunction

    assign w_tick  = vsync & ~r_vsync_d;
    assign w_bx_mv = r_dir_x ? $signed({1'b0, r_ball_x}) + C_BSPD : $signed({1'b0, r_ball_x}) - C_BSPD;
    assign w_by_mv = r_dir_y ? $signed({1'b0, r_ball_y}) + C_BSPD : $signed({1'b0, r_ball_y}) - C_BSPD;
    assign w_ov_l  = ({1'b0, r_ball_y} + C_BSZ > {1'b0, r_pad_l}) && ({1'b0, r_ball_y} < {1'b0, r_pad_l} + C_PADH);
    assign w_ov_r  = ({1'b0, r_ball_y} + C_BSZ > {1'b0, r_pad_r}) && ({1'b0, r_ball_y} < {1'b0, r_pad_r} + C_PADH);
    // Centre comparisons shifted by PAD_SPEED on both sides so nothing goes negative.
    assign w_ai_dn = ({1'b0, r_pad_r} + C_HALF_PADH + C_PSPD11) < ({1'b0, r_ball_y} + C_HALF_BSZ);
    assign w_ai_up = ({1'b0, r_pad_r} + C_HALF_PADH) > ({1'b0, r_ball_y} + C_HALF_BSZ + C_PSPD11);
    assign w_pad_l_step = pad_step(r_pad_l, up_l, dn_l);
`ifdef PONG_AI_EN
    assign w_pad_r_step = pad_step(r_pad_r, w_ai_up, w_ai_dn);
`else
    assign w_pad_r_step = pad_step(r_pad_r, up_r, dn_r);
`endif

    // Next-state and next-value logic for the frame sequence.
    always_comb begin
        w_state     = r_state;
        w_ball_x    = r_ball_x;
        w_ball_y    = r_ball_y;
        w_pad_l     = r_pad_l;
        w_pad_r     = r_pad_r;
        w_score_l   = r_score_l;
        w_score_r   = r_score_r;
        w_dir_x     = r_dir_x;
        w_dir_y     = r_dir_y;
        w_loser_l   = r_loser_l;
        case (r_state)
            S_SERVE: begin
                w_ball_x = C_BALL_X0;
                w_ball_y = C_BALL_Y0;
                if (serve) begin
                    w_state = S_WAIT_TICK;
                end else if (w_tick) begin
                    w_pad_l = w_pad_l_step;
                    w_pad_r = w_pad_r_step;
                end else begin
                    w_state = S_SERVE;
                end
            end
            S_WAIT_TICK: begin
                if (w_tick) begin
                    w_state = S_MOVE_PAD;
                end else begin
                    w_state = S_WAIT_TICK;
                end
            end
            S_MOVE_PAD: begin
                w_pad_l = w_pad_l_step;
                w_pad_r = w_pad_r_step;
                w_state = S_MOVE_BALL;
            end
            S_MOVE_BALL: begin
                if (w_bx_mv < 11'sd0) begin
                    w_ball_x = 10'd0;
                end else if (w_bx_mv > C_BX_MAX) begin
                    w_ball_x = C_BX_MAX[9:0];
                end else begin
                    w_ball_x = w_bx_mv[9:0];
                end
                if (w_by_mv < 11'sd0) begin
                    w_ball_y = 10'd0;
                    w_dir_y  = 1'b1;
                end else if (w_by_mv > C_BY_MAX) begin
                    w_ball_y = C_BY_MAX[9:0];
                    w_dir_y  = 1'b0;
                end else begin
                    w_ball_y = w_by_mv[9:0];
                end
                w_state = S_CHECK;
            end
            S_CHECK: begin
                if (!r_dir_x && ({1'b0, r_ball_x} <= C_XL_EDGE) && ({1'b0, r_ball_x} + C_BSZ > C_XL) && w_ov_l) begin
                    w_ball_x = C_BX_HIT_L;
                    w_dir_x  = 1'b1;
                    w_state  = S_WAIT_TICK;
                end else if (r_dir_x && ({1'b0, r_ball_x} + C_BSZ >= C_XR) && ({1'b0, r_ball_x} < C_XR_EDGE) && w_ov_r) begin
                    w_ball_x = C_BX_HIT_R;
                    w_dir_x  = 1'b0;
                    w_state  = S_WAIT_TICK;
                end else if (r_ball_x == 10'd0) begin
                    w_loser_l = 1'b1;
                    w_state   = S_POINT;
                end else if (r_ball_x == C_BX_GOAL_R) begin
                    w_loser_l = 1'b0;
                    w_state   = S_POINT;
                end else begin
                    w_state = S_WAIT_TICK;
                end
            end
            S_POINT: begin
                if (r_loser_l) begin
                    w_score_r = r_score_r + 4'd1;
                end else begin
                    w_score_l = r_score_l + 4'd1;
                end
                if ((r_loser_l ? w_score_r : w_score_l) == C_WIN) begin
                    w_state = S_GAME_OVER;
                end else begin
                    w_ball_x = C_BALL_X0;
                    w_ball_y = C_BALL_Y0;
                    w_dir_x  = ~r_loser_l;
                    w_dir_y  = 1'b1;
                    w_state  = S_SERVE;
                end
            end
            S_GAME_OVER: begin
                if (serve) begin
                    w_score_l = 4'd0;
                    w_score_r = 4'd0;
                    w_ball_x  = C_BALL_X0;
                    w_ball_y  = C_BALL_Y0;
                    w_pad_l   = C_PAD_Y0;
                    w_pad_r   = C_PAD_Y0;
                    w_dir_x   = 1'b1;
                    w_dir_y   = 1'b1;
                    w_state   = S_SERVE;
                end else begin
                    w_state = S_GAME_OVER;
                end
            end
            default: begin
                w_state = S_SERVE;
            end
        endcase
        w_playing   = (w_state == S_WAIT_TICK) || (w_state == S_MOVE_PAD) ||
                      (w_state == S_MOVE_BALL) || (w_state == S_CHECK);
        w_game_over = (w_state == S_GAME_OVER);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_SERVE;
            r_vsync_d   <= 1'b0;
            r_ball_x    <= C_BALL_X0;
            r_ball_y    <= C_BALL_Y0;
            r_pad_l     <= C_PAD_Y0;
            r_pad_r     <= C_PAD_Y0;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_loser_l   <= 1'b0;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_vsync_d   <= vsync;
            r_ball_x    <= w_ball_x;
            r_ball_y    <= w_ball_y;
            r_pad_l     <= w_pad_l;
            r_pad_r     <= w_pad_r;
            r_score_l   <= w_score_l;
            r_score_r   <= w_score_r;
            r_dir_x     <= w_dir_x;
            r_dir_y     <= w_dir_y;
            r_loser_l   <= w_loser_l;
            r_playing   <= w_playing;
            r_game_over <= w_game_over;
        end
    end

    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign pad_l_y   = r_pad_l;
    assign pad_r_y   = r_pad_r;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign playing   = r_playing;
    assign game_over = r_game_over;

endmodule
